board_state_ctrl: RTL and testbench

//  Game-board owner for the tic-tac-toe learner. It accepts moves from the learning agent and
//  the opponent over a valid/ready handshake, and enforces turn order and cell legality.
//  It maintains the 18-bit packed board that reward logic consumes, and flags win/draw/game-over.

---
 rtl/board_state_ctrl.sv | 149 ++++++++++++++
 tb/tb_board_state_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/board_state_ctrl.sv
// rtl/board_state_ctrl.sv - tic-tac-toe board owner: turn order, move legality, win/draw detection
module board_state_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [1:0]  move_player,
  input  logic [3:0]  move_cell,
  output logic [17:0] current_state,
  output logic [1:0]  turn,
  output logic        move_ok,
  output logic        move_err,
  output logic [1:0]  err_code,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  turn_q, turn_d;
  logic        move_ok_q, move_ok_d;
  logic        move_err_q, move_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q, winner_d;

  logic [4:0]  cell_lo;
  logic [1:0]  line_win;

  function automatic logic [1:0] line3(input logic [17:0] b, input int a, input int c, input int d);
    logic [1:0] va, vc, vd;
    va = b[2*a +: 2];
    vc = b[2*c +: 2];
    vd = b[2*d +: 2];
    if ((va == vc) && (va == vd) && ((va == 2'd1) || (va == 2'd2))) return va;
    return 2'd0;
  endfunction

  // Only the mover can complete a line, so any non-zero line result names the winner.
  function automatic logic [1:0] board_winner(input logic [17:0] b);
    logic [1:0] w;
    w = line3(b, 0, 1, 2) | line3(b, 3, 4, 5) | line3(b, 6, 7, 8)
      | line3(b, 0, 3, 6) | line3(b, 1, 4, 7) | line3(b, 2, 5, 8)
      | line3(b, 0, 4, 8) | line3(b, 2, 4, 6);
    return w;
  endfunction

  assign cell_lo    = {move_cell, 1'b0};
  assign line_win   = board_winner(board_q);
  assign move_ready = (state_q == PLAY) & ~new_game;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    count_d     = count_q;
    turn_d      = turn_q;
    move_ok_d   = 1'b0;
    move_err_d  = 1'b0;
    err_code_d  = err_code_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (new_game) begin
      state_d     = PLAY;
      board_d     = '0;
      count_d     = '0;
      turn_d      = FIRST_PLAYER;
      game_over_d = 1'b0;
      winner_d    = 2'd0;
    end else begin
      case (state_q)
        PLAY: begin
          if (move_valid) begin
            if ((move_cell > 4'd8) || !((move_player == 2'd1) || (move_player == 2'd2))) begin
              move_err_d = 1'b1;
              err_code_d = 2'd3;
            end else if (move_player != turn_q) begin
              move_err_d = 1'b1;
              err_code_d = 2'd2;
            end else if (board_q[cell_lo +: 2] != 2'd0) begin
              move_err_d = 1'b1;
              err_code_d = 2'd1;
            end else begin
              board_d[cell_lo +: 2] = move_player;
              count_d   = count_q + 4'd1;
              move_ok_d = 1'b1;
              state_d   = CHECK;
            end
          end
        end
        CHECK: begin
          if (line_win != 2'd0) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = line_win;
          end else if (count_q == 4'd9) begin
            state_d     = DONE;
            game_over_d = 1'b1;
            winner_d    = 2'd0;
          end else begin
            turn_d  = (turn_q == 2'd1) ? 2'd2 : 2'd1;
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      board_q     <= '0;
      count_q     <= '0;
      turn_q      <= 2'd0;
      move_ok_q   <= 1'b0;
      move_err_q  <= 1'b0;
      err_code_q  <= 2'd0;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      count_q     <= count_d;
      turn_q      <= turn_d;
      move_ok_q   <= move_ok_d;
      move_err_q  <= move_err_d;
      err_code_q  <= err_code_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign current_state = board_q;
  assign turn          = ((state_q == PLAY) || (state_q == CHECK)) ? turn_q : 2'd0;
  assign move_ok       = move_ok_q;
  assign move_err      = move_err_q;
  assign err_code      = err_code_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign move_count    = count_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb/tb_board_state_ctrl.sv - scoreboard bench for board_state_ctrl
module tb_board_state_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic        move_ready;
  logic [1:0]  move_player = 2'd0;
  logic [3:0]  move_cell = 4'd0;
  logic [17:0] current_state;
  logic [1:0]  turn;
  logic        move_ok;
  logic        move_err;
  logic [1:0]  err_code;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  move_count;

  typedef struct packed {
    logic        ok;
    logic [1:0]  code;
    logic [17:0] brd;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  board_state_ctrl #(.FIRST_PLAYER(2'd1)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_player(move_player), .move_cell(move_cell),
    .current_state(current_state), .turn(turn),
    .move_ok(move_ok), .move_err(move_err), .err_code(err_code),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: every move_ok/move_err pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && (move_ok || move_err)) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_response: got ok=%0b err=%0b expected none", move_ok, move_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_ok", {31'd0, move_ok}, {31'd0, e.ok});
        chk("resp_err", {31'd0, move_err}, {31'd0, ~e.ok});
        if (!e.ok) chk("resp_err_code", {30'd0, err_code}, {30'd0, e.code});
        chk("resp_board", {14'd0, current_state}, {14'd0, e.brd});
      end
    end
  end

  task automatic start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] p, input logic [3:0] c,
                         input logic ok, input logic [1:0] code, input logic [17:0] brd);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    move_valid  = 1'b1;
    move_player = p;
    move_cell   = c;
    while (!move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!move_ready) begin
      total_cnt++;
      $display("FAIL handshake_timeout: got ready=0 expected ready=1 within 20 cycles");
      move_valid = 1'b0;
      return;
    end
    e.ok = ok;
    e.code = code;
    e.brd = brd;
    exp_q.push_back(e);
    @(posedge clk);
    #1 move_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_board", {14'd0, current_state}, 32'd0);
    chk("reset_turn", {30'd0, turn}, 32'd0);
    chk("reset_ready", {31'd0, move_ready}, 32'd0);
    chk("reset_count", {28'd0, move_count}, 32'd0);
    chk("reset_err_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;

    // 1: new game
    start_game();
    @(negedge clk);
    chk("t1_board", {14'd0, current_state}, 32'd0);
    chk("t1_turn", {30'd0, turn}, 32'd1);
    chk("t1_ready", {31'd0, move_ready}, 32'd1);
    chk("t1_game_over", {31'd0, game_over}, 32'd0);
    chk("t1_count", {28'd0, move_count}, 32'd0);

    // 2: agent wins on the main diagonal
    do_move(2'd1, 4'd0, 1'b1, 2'd0, 18'h00001);
    do_move(2'd2, 4'd1, 1'b1, 2'd0, 18'h00009);
    do_move(2'd1, 4'd4, 1'b1, 2'd0, 18'h00109);
    do_move(2'd2, 4'd2, 1'b1, 2'd0, 18'h00129);
    do_move(2'd1, 4'd8, 1'b1, 2'd0, 18'h10129);
    repeat (2) @(negedge clk);
    chk("t2_board", {14'd0, current_state}, 32'h10129);
    chk("t2_game_over", {31'd0, game_over}, 32'd1);
    chk("t2_winner", {30'd0, winner}, 32'd1);
    chk("t2_count", {28'd0, move_count}, 32'd5);
    chk("t2_ready", {31'd0, move_ready}, 32'd0);
    chk("t2_turn", {30'd0, turn}, 32'd0);

    // 3: occupied cell
    start_game();
    do_move(2'd1, 4'd4, 1'b1, 2'd0, 18'h00100);
    do_move(2'd2, 4'd4, 1'b0, 2'd1, 18'h00100);
    @(negedge clk);
    chk("t3_turn", {30'd0, turn}, 32'd2);
    chk("t3_count", {28'd0, move_count}, 32'd1);

    // 4: wrong player, then bad cell
    start_game();
    do_move(2'd1, 4'd0, 1'b1, 2'd0, 18'h00001);
    do_move(2'd1, 4'd1, 1'b0, 2'd2, 18'h00001);
    do_move(2'd2, 4'd9, 1'b0, 2'd3, 18'h00001);
    do_move(2'd3, 4'd5, 1'b0, 2'd3, 18'h00001);
    @(negedge clk);
    chk("t4_err_code_held", {30'd0, err_code}, 32'd3);
    chk("t4_count", {28'd0, move_count}, 32'd1);

    // 5: full-board draw
    start_game();
    do_move(2'd1, 4'd0, 1'b1, 2'd0, 18'h00001);
    do_move(2'd2, 4'd1, 1'b1, 2'd0, 18'h00009);
    do_move(2'd1, 4'd2, 1'b1, 2'd0, 18'h00019);
    do_move(2'd2, 4'd4, 1'b1, 2'd0, 18'h00219);
    do_move(2'd1, 4'd3, 1'b1, 2'd0, 18'h00259);
    do_move(2'd2, 4'd5, 1'b1, 2'd0, 18'h00A59);
    do_move(2'd1, 4'd7, 1'b1, 2'd0, 18'h04A59);
    do_move(2'd2, 4'd6, 1'b1, 2'd0, 18'h06A59);
    do_move(2'd1, 4'd8, 1'b1, 2'd0, 18'h16A59);
    repeat (2) @(negedge clk);
    chk("t5_game_over", {31'd0, game_over}, 32'd1);
    chk("t5_winner", {30'd0, winner}, 32'd0);
    chk("t5_count", {28'd0, move_count}, 32'd9);
    move_valid = 1'b1;
    move_player = 2'd2;
    move_cell = 4'd3;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_ready", {31'd0, move_ready}, 32'd0);
    end
    move_valid = 1'b0;
    chk("t5_board_held", {14'd0, current_state}, 32'h16A59);

    // 6: new_game collides with move_valid, then asynchronous reset mid-game
    start_game();
    do_move(2'd1, 4'd4, 1'b1, 2'd0, 18'h00100);
    @(negedge clk);
    new_game = 1'b1;
    move_valid = 1'b1;
    move_player = 2'd2;
    move_cell = 4'd0;
    #1 chk("t6_ready_blocked", {31'd0, move_ready}, 32'd0);
    @(posedge clk);
    #1 new_game = 1'b0;
    move_valid = 1'b0;
    @(negedge clk);
    chk("t6_board_cleared", {14'd0, current_state}, 32'd0);
    chk("t6_move_ok", {31'd0, move_ok}, 32'd0);
    do_move(2'd1, 4'd2, 1'b1, 2'd0, 18'h00010);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_board", {14'd0, current_state}, 32'd0);
    chk("t6_rst_count", {28'd0, move_count}, 32'd0);
    chk("t6_rst_turn", {30'd0, turn}, 32'd0);
    chk("t6_rst_ready", {31'd0, move_ready}, 32'd0);
    chk("t6_rst_flags", {26'd0, move_ok, move_err, err_code, game_over, winner != 2'd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_reset", {31'd0, move_ready}, 32'd0);

    repeat (3) @(negedge clk);
    chk("pending_responses", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
